mul_share_sched: RTL and testbench



---
 rtl/mul_share_pkg.sv | 21 ++
 rtl/mul_share_rr_arb.sv | 51 +++++
 rtl/mul_share_sched.sv | 102 ++++++++++
 tb/tb_mul_share_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler.
package mul_share_pkg;

    // Width of the issued-operation counter.
    localparam int OP_CNT_W = 16;

    // Widest requester id needed (NREQ up to 8).
    localparam int MAX_IDW = 3;

    // Requester id width: max(1, clog2(n)).
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One tag pipeline stage: marks a product in flight and its owner.
    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_share_rr_arb.sv
// Round-robin arbiter. The search starts at rr_ptr, and the pointer moves past
// the winner only when the grant turns into a completed issue.
module mul_share_rr_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = calc_idw(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_any,
    output logic [IDW-1:0]  rr_ptr
);

    int             sum;
    logic [IDW-1:0] idx;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NREQ) sum = sum - NREQ;
            idx = IDW'(sum);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

    // Pointer moves to winner+1 (mod NREQ) on each completed issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            if (int'(grant_id) == NREQ - 1) rr_ptr <= '0;
            else                            rr_ptr <= grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Time-multiplexes one external pipelined multiplier between NREQ requesters.
// Handshake: a transfer on any channel happens on a rising edge where that
// channel's valid and ready are both high. req_ready is high only for the
// round-robin winner when the pipeline is not stalled. rsp_valid is high for
// the owner of the product in the last tag stage. If the owner's rsp_ready is
// low, the multiplier and the tag pipeline freeze together (mul_ce low), so
// rsp_p stays stable until it is taken.
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ASIZE   = 15,
    parameter int BSIZE   = 11,
    parameter int MUL_LAT = 1,
    localparam int PSIZE  = ASIZE + BSIZE,
    localparam int IDW    = calc_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ASIZE-1:0] req_a,
    input  logic [NREQ*BSIZE-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [PSIZE-1:0]      rsp_p,
    output logic                  mul_ce,
    output logic [ASIZE-1:0]      mul_a,
    output logic [BSIZE-1:0]      mul_b,
    input  logic [PSIZE-1:0]      mul_p,
    output logic [OP_CNT_W-1:0]   op_cnt
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic [IDW-1:0]  rr_ptr;
    logic            stall;
    logic            issue;
    tag_t            tags [MUL_LAT];
    tag_t            tag_last;

    mul_share_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (issue),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any),
        .rr_ptr    (rr_ptr)
    );

    assign tag_last = tags[MUL_LAT-1];

    // Response steering and stall detection from the last tag stage.
    // Reset overrides everything so a stall releases immediately.
    always_comb begin
        rsp_valid = '0;
        stall     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rst && tag_last.valid && tag_last.id == MAX_IDW'(i)) begin
                rsp_valid[i] = 1'b1;
                stall        = !rsp_ready[i];
            end
        end
    end

    assign rsp_p     = (!rst && tag_last.valid) ? mul_p : '0;
    assign mul_ce    = !stall;
    assign req_ready = (stall || rst) ? '0 : grant;
    assign issue     = |req_ready;

    // Operand mux: winner's operands, zero when nobody is requesting.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mul_a = req_a[i*ASIZE +: ASIZE];
                mul_b = req_b[i*BSIZE +: BSIZE];
            end
        end
    end

    // Tag shift register, advancing in lock-step with the multiplier stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) tags[k] <= '0;
        end else if (mul_ce) begin
            tags[0] <= {issue, MAX_IDW'(grant_id)};
            for (int k = 1; k < MUL_LAT; k++) tags[k] <= tags[k-1];
        end
    end

    // Issued-operation counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst)        op_cnt <= '0;
        else if (issue) op_cnt <= op_cnt + 1'b1;
    end

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched: one instance with MUL_LAT=1 and one
// with MUL_LAT=3, each driving a behavioural clock-enabled multiplier.
module tb_mul_share_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // MUL_LAT=1 instance signals
    logic [3:0]  v1 = '0, r1, rv1, rr1 = 4'hF;
    logic [59:0] a1 = '0;
    logic [43:0] b1 = '0;
    logic [25:0] p1, mp1;
    logic        ce1;
    logic [14:0] ma1;
    logic [10:0] mb1;
    logic [15:0] cnt1;
    logic [25:0] pipe1 = '0;

    // MUL_LAT=3 instance signals
    logic [3:0]  v3 = '0, r3, rv3, rr3 = 4'hF;
    logic [59:0] a3 = '0;
    logic [43:0] b3 = '0;
    logic [25:0] p3, mp3;
    logic        ce3;
    logic [14:0] ma3;
    logic [10:0] mb3;
    logic [15:0] cnt3;
    logic [25:0] pipe3 [3] = '{default: '0};

    mul_share_sched #(.NREQ(4), .ASIZE(15), .BSIZE(11), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1), .req_a(a1), .req_b(b1),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_p(p1), .mul_ce(ce1), .mul_a(ma1),
        .mul_b(mb1), .mul_p(mp1), .op_cnt(cnt1)
    );

    mul_share_sched #(.NREQ(4), .ASIZE(15), .BSIZE(11), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3), .req_a(a3), .req_b(b3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_p(p3), .mul_ce(ce3), .mul_a(ma3),
        .mul_b(mb3), .mul_p(mp3), .op_cnt(cnt3)
    );

    // External multiplier models with pipeline registers gated by ce.
    always @(posedge clk) if (ce1) pipe1 <= ma1 * mb1;
    assign mp1 = pipe1;

    always @(posedge clk) begin
        if (ce3) begin
            pipe3[0] <= ma3 * mb3;
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign mp3 = pipe3[2];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v1 = '0; v3 = '0; rr1 = 4'hF; rr3 = 4'hF;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; v1 = '0; v3 = '0;
        @(negedge clk);
        total++; if (r1 !== 4'b0) begin bad++; $display("FAIL rst_ready: got %b exp 0000", r1); end
        total++; if (rv1 !== 4'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b exp 0000", rv1); end
        total++; if (p1 !== 26'd0) begin bad++; $display("FAIL rst_rsp_p: got %0h exp 0", p1); end
        total++; if (ce1 !== 1'b1) begin bad++; $display("FAIL rst_mul_ce: got %b exp 1", ce1); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (cnt1 !== 16'd0) begin bad++; $display("FAIL rst_op_cnt: got %0h exp 0", cnt1); end
        total++; if (cnt3 !== 16'd0) begin bad++; $display("FAIL rst_op_cnt3: got %0h exp 0", cnt3); end
        total++; if (rv1 !== 4'b0 || r1 !== 4'b0) begin bad++; $display("FAIL post_rst_hs: got rv=%b rdy=%b exp 0000", rv1, r1); end
        total++; if (ma1 !== 15'd0 || mb1 !== 11'd0) begin bad++; $display("FAIL post_rst_ops: got a=%0h b=%0h exp 0", ma1, mb1); end
        total++; if (ce3 !== 1'b1 || rv3 !== 4'b0) begin bad++; $display("FAIL post_rst3: got ce=%b rv=%b exp 1/0000", ce3, rv3); end
        next_cycle();
    endtask

    task automatic test_single();
        do_reset();
        v1 = 4'b0100;
        a1[2*15 +: 15] = 15'h7FFF;
        b1[2*11 +: 11] = 11'h7FF;
        @(negedge clk);
        total++; if (r1 !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b exp 0100", r1); end
        total++; if (ma1 !== 15'h7FFF || mb1 !== 11'h7FF) begin bad++; $display("FAIL single_ops: got a=%0h b=%0h exp 7fff/7ff", ma1, mb1); end
        next_cycle();
        v1 = '0;
        @(negedge clk);
        total++; if (rv1 !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid: got %b exp 0100", rv1); end
        total++; if (p1 !== 26'h3FF7801) begin bad++; $display("FAIL single_rsp_p: got %0h exp 3ff7801", p1); end
        total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL single_op_cnt: got %0d exp 1", cnt1); end
        next_cycle();
        @(negedge clk);
        total++; if (rv1 !== 4'b0 || p1 !== 26'd0) begin bad++; $display("FAIL single_idle: got rv=%b p=%0h exp 0000/0", rv1, p1); end
        next_cycle();
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_g;
        logic [3:0]  exp_r;
        logic [25:0] exp_p;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a1[i*15 +: 15] = 15'(i + 1);
            b1[i*11 +: 11] = 11'(i + 2);
        end
        v1 = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) v1 = '0;
            @(negedge clk);
            if (c < 8) begin
                exp_g = 4'(1 << (c % 4));
                total++; if (r1 !== exp_g) begin bad++; $display("FAIL fair_grant[%0d]: got %b exp %b", c, r1, exp_g); end
            end
            if (c > 0) begin
                exp_r = 4'(1 << ((c - 1) % 4));
                exp_p = 26'((((c - 1) % 4) + 1) * (((c - 1) % 4) + 2));
                total++; if (rv1 !== exp_r || p1 !== exp_p) begin bad++; $display("FAIL fair_rsp[%0d]: got rv=%b p=%0d exp %b/%0d", c, rv1, p1, exp_r, exp_p); end
            end
            next_cycle();
        end
        @(negedge clk);
        total++; if (cnt1 !== 16'd8) begin bad++; $display("FAIL fair_op_cnt: got %0d exp 8", cnt1); end
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        a1[1*15 +: 15] = 15'd3; b1[1*11 +: 11] = 11'd5;
        a1[0*15 +: 15] = 15'd7; b1[0*11 +: 11] = 11'd7;
        v1 = 4'b0010;
        rr1 = 4'b1101;
        @(negedge clk);
        total++; if (r1 !== 4'b0010) begin bad++; $display("FAIL stall_issue: got %b exp 0010", r1); end
        next_cycle();
        v1 = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++; if (rv1 !== 4'b0010 || p1 !== 26'd15) begin bad++; $display("FAIL stall_hold[%0d]: got rv=%b p=%0d exp 0010/15", c, rv1, p1); end
            total++; if (ce1 !== 1'b0 || r1 !== 4'b0) begin bad++; $display("FAIL stall_freeze[%0d]: got ce=%b rdy=%b exp 0/0000", c, ce1, r1); end
            next_cycle();
        end
        rr1 = 4'hF;
        @(negedge clk);
        total++; if (rv1 !== 4'b0010 || p1 !== 26'd15) begin bad++; $display("FAIL stall_release_rsp: got rv=%b p=%0d exp 0010/15", rv1, p1); end
        total++; if (ce1 !== 1'b1 || r1 !== 4'b0001) begin bad++; $display("FAIL stall_release_issue: got ce=%b rdy=%b exp 1/0001", ce1, r1); end
        next_cycle();
        v1 = '0;
        @(negedge clk);
        total++; if (rv1 !== 4'b0001 || p1 !== 26'd49) begin bad++; $display("FAIL stall_after: got rv=%b p=%0d exp 0001/49", rv1, p1); end
        total++; if (cnt1 !== 16'd2) begin bad++; $display("FAIL stall_op_cnt: got %0d exp 2", cnt1); end
        next_cycle();
    endtask

    task automatic test_lat3();
        do_reset();
        a3[0*15 +: 15] = 15'd1; b3[0*11 +: 11] = 11'd2;
        a3[3*15 +: 15] = 15'd4; b3[3*11 +: 11] = 11'd5;
        v3 = 4'b1001;
        @(negedge clk);
        total++; if (r3 !== 4'b0001) begin bad++; $display("FAIL lat3_grant0: got %b exp 0001", r3); end
        next_cycle();
        v3 = 4'b1000;
        @(negedge clk);
        total++; if (r3 !== 4'b1000) begin bad++; $display("FAIL lat3_grant1: got %b exp 1000", r3); end
        next_cycle();
        v3 = '0;
        @(negedge clk);
        total++; if (rv3 !== 4'b0) begin bad++; $display("FAIL lat3_early: got %b exp 0000", rv3); end
        next_cycle();
        @(negedge clk);
        total++; if (rv3 !== 4'b0001 || p3 !== 26'd2) begin bad++; $display("FAIL lat3_rsp0: got rv=%b p=%0d exp 0001/2", rv3, p3); end
        next_cycle();
        @(negedge clk);
        total++; if (rv3 !== 4'b1000 || p3 !== 26'd20) begin bad++; $display("FAIL lat3_rsp1: got rv=%b p=%0d exp 1000/20", rv3, p3); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        a3[0*15 +: 15] = 15'd6; b3[0*11 +: 11] = 11'd6;
        a3[1*15 +: 15] = 15'd9; b3[1*11 +: 11] = 11'd9;
        v3 = 4'b0011;
        next_cycle();
        next_cycle();
        v3 = '0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (cnt3 !== 16'd2) begin bad++; $display("FAIL rmid_inflight: got %0d exp 2", cnt3); end
        total++; if (rv3 !== 4'b0 || r3 !== 4'b0 || ce3 !== 1'b1) begin bad++; $display("FAIL rmid_during: got rv=%b rdy=%b ce=%b exp 0000/0000/1", rv3, r3, ce3); end
        next_cycle();
        rst = 1'b0;
        v3 = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++; if (cnt3 !== 16'd0) begin bad++; $display("FAIL rmid_op_cnt: got %0d exp 0", cnt3); end
                total++; if (r3 !== 4'b0001) begin bad++; $display("FAIL rmid_grant: got %b exp 0001", r3); end
            end
            total++; if (rv3 !== 4'b0) begin bad++; $display("FAIL rmid_no_rsp[%0d]: got %b exp 0000", c, rv3); end
            next_cycle();
            v3 = '0;
        end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        a1[0*15 +: 15] = 15'd2; b1[0*11 +: 11] = 11'd3;
        v1 = 4'b0001;
        for (int c = 0; c < 65535; c++) begin
            if (c < 2) begin
                @(negedge clk);
                total++; if (r1 !== 4'b0001) begin bad++; $display("FAIL b2b_ready[%0d]: got %b exp 0001", c, r1); end
            end
            next_cycle();
        end
        v1 = '0;
        @(negedge clk);
        total++; if (cnt1 !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %0h exp ffff", cnt1); end
        total++; if (rv1 !== 4'b0001 || p1 !== 26'd6) begin bad++; $display("FAIL b2b_rsp: got rv=%b p=%0d exp 0001/6", rv1, p1); end
        next_cycle();
        v1 = 4'b0001;
        next_cycle();
        v1 = '0;
        @(negedge clk);
        total++; if (cnt1 !== 16'h0000) begin bad++; $display("FAIL wrap: got %0h exp 0000", cnt1); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_lat3();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
